bp_me_best_offset_scheduler: RTL and testbench
==============================================

Name: bp_me_best_offset_scheduler

Overview:
- Sequences the learning phase of the best-offset prefetcher: pops demand-miss addresses and tests one candidate offset per miss against the recent-requests (RR) table.
- Scores each candidate, ends a phase on score saturation or round limit, publishes the winning offset, then clears scores and restarts.
- Sits between the miss-address FIFO and the RR table lookup port. Drives the offset consumed by the prefetch issue logic.

Parameters:
- daddr_width_p, 64, physical address width
- lg_offsets_p, 4, log2 number of candidate offsets; candidate i tests offset i+1 blocks
- block_offset_width_p, 6, log2 cache block bytes
- score_width_p, 5, width of each score counter
- score_max_p, 31, score that ends a phase early; must be < 2^score_width_p
- round_max_p, 100, maximum rounds per phase
- bad_score_p, 1, best score must exceed this for prefetch to be enabled

Ports:
- clk_i, in, 1, clock
- reset_i, in, 1, synchronous active-high reset
- miss_addr_i, in, daddr_width_p, miss address at head of FIFO
- miss_v_i, in, 1, FIFO head valid
- miss_yumi_o, out, 1, pop FIFO head this cycle
- rr_addr_o, out, daddr_width_p, RR lookup address
- rr_v_o, out, 1, RR lookup request valid
- rr_ready_and_i, in, 1, RR port accepts request
- rr_hit_v_i, in, 1, RR response valid
- rr_hit_i, in, 1, RR response hit
- offset_o, out, lg_offsets_p+1, selected offset in blocks
- offset_v_o, out, 1, offset_o usable; prefetch enabled
- phase_done_o, out, 1, one-cycle pulse when a phase's result is published

Behaviour:
- Reset values: miss_yumi_o=0, rr_v_o=0, offset_o=0, offset_v_o=0, phase_done_o=0, rr_addr_o=0. Candidate index, round count, best_score and best_idx are all 0. FSM enters e_clear.
- e_clear: writes one score entry to 0 per cycle, 2^lg_offsets_p cycles, then goes to e_idle. Clears best_score, best_idx, cand_idx and round_cnt.
- e_idle: miss_yumi_o = miss_v_i. On a pop, latch miss_addr_i and go to e_probe.
- e_probe: rr_v_o=1 and rr_addr_o = latched_addr - ((cand_idx+1) << block_offset_width_p). Subtraction is modulo 2^daddr_width_p, so it wraps silently. Hold the request until rr_ready_and_i, then go to e_wait.
- e_wait: wait for rr_hit_v_i. Responses are in order, one outstanding. Then go to e_update.
- e_update, one cycle:
  - If rr_hit_i was captured high, score[cand_idx]++ (saturating at score_max_p).
  - If new score > best_score: best_score=new score, best_idx=cand_idx. Strict compare, so on a tie the lower index wins.
  - If cand_idx == 2^lg_offsets_p-1: cand_idx wraps to 0 and round_cnt++. Otherwise cand_idx++.
  - Go to e_publish if new score == score_max_p or incremented round_cnt == round_max_p. Otherwise go to e_idle.
- e_publish, one cycle:
  - offset_o = best_idx+1.
  - offset_v_o = (best_score > bad_score_p).
  - phase_done_o=1.
  - Then go to e_clear.
- offset_o and offset_v_o hold their values through the next phase until the next e_publish. They update in the same cycle as phase_done_o.
- rr_hit_v_i outside e_wait is ignored. miss_v_i outside e_idle is not popped.
- Reset mid-operation aborts any outstanding RR request. A late response arriving after reset is ignored. Published offset returns to 0 and invalid.
- Latency: minimum 4 cycles from pop to the next possible pop (idle, probe, wait, update) with zero-latency ready and response.

Optional Feature:
- BP_ME_BO_SCHED_STATS_EN: adds output phase_cnt_o (32 bits) and output disabled_cnt_o (32 bits).
  - phase_cnt_o counts e_publish cycles.
  - disabled_cnt_o counts publishes with offset_v_o=0.
  - Both reset to 0 and wrap at 2^32.
- Without the macro these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
All scenarios use lg_offsets_p=2, score_max_p=3, round_max_p=4 and bad_score_p=1.
- Reset: hold reset_i 3 cycles with miss_v_i=1. Response: miss_yumi_o=0 during reset and for 4 cycles after (e_clear), offset_v_o=0, first pop on cycle 5.
- Address arithmetic: miss 0x1000 with cand_idx=2, block_offset_width_p=6. Response: rr_addr_o=0x0F40. Miss 0x40 with cand_idx=1 gives rr_addr_o=0xFFFF_FFFF_FFFF_FFC0 (wrap).
- Early saturation: RR hits only for offset 3 (idx 2). Response: phase_done_o after 11 misses (3rd round, idx 2), offset_o=3, offset_v_o=1.
- Round limit, no winner: all responses miss for 16 misses. Response: phase_done_o on the 16th update, offset_v_o=0, offset_o=1.
- Tie: idx 1 and idx 3 each hit in 2 of 4 rounds, others never hit. Response: offset_o=2, offset_v_o=1 after 16 misses.
- Backpressure/ordering: hold rr_ready_and_i=0 for 5 cycles, then delay the response 3 cycles, injecting a stray rr_hit_v_i during e_idle. Response: rr_addr_o stable while rr_v_o is high, stray response has no score effect, exactly one pop per update.

Source files
------------

// File: rtl/bp_me_best_offset_scheduler.sv
// Best-offset prefetcher learning-phase sequencer: probes one candidate offset per demand miss,
// scores hits, and publishes the winning offset. Define BP_ME_BO_SCHED_STATS_EN for publish counters.
module bp_me_best_offset_scheduler
  #(parameter int daddr_width_p        = 64
  , parameter int lg_offsets_p         = 4
  , parameter int block_offset_width_p = 6
  , parameter int score_width_p        = 5
  , parameter int score_max_p          = 31
  , parameter int round_max_p          = 100
  , parameter int bad_score_p          = 1
  )
  ( input  logic                       clk_i
  , input  logic                       reset_i
  , input  logic [daddr_width_p-1:0]   miss_addr_i
  , input  logic                       miss_v_i
  , output logic                       miss_yumi_o
  , output logic [daddr_width_p-1:0]   rr_addr_o
  , output logic                       rr_v_o
  , input  logic                       rr_ready_and_i
  , input  logic                       rr_hit_v_i
  , input  logic                       rr_hit_i
  , output logic [lg_offsets_p:0]      offset_o
  , output logic                       offset_v_o
  , output logic                       phase_done_o
`ifdef BP_ME_BO_SCHED_STATS_EN
  , output logic [31:0]                phase_cnt_o
  , output logic [31:0]                disabled_cnt_o
`endif
  );

    localparam int num_offsets_lp = 1 << lg_offsets_p;
    localparam int round_width_lp = $clog2(round_max_p + 1);
    localparam logic [score_width_p-1:0]  score_max_lp = score_width_p'(score_max_p);
    localparam logic [score_width_p-1:0]  bad_score_lp = score_width_p'(bad_score_p);
    localparam logic [round_width_lp-1:0] round_max_lp = round_width_lp'(round_max_p);

    typedef enum logic [2:0] {
        e_clear   = 3'd0,
        e_idle    = 3'd1,
        e_probe   = 3'd2,
        e_wait    = 3'd3,
        e_update  = 3'd4,
        e_publish = 3'd5
    } state_e;

    state_e                     state_q, state_d;
    logic [lg_offsets_p-1:0]    clr_idx_q, clr_idx_d;
    logic [lg_offsets_p-1:0]    cand_idx_q, cand_idx_d;
    logic [round_width_lp-1:0]  round_cnt_q, round_cnt_d;
    logic [score_width_p-1:0]   best_score_q, best_score_d;
    logic [lg_offsets_p-1:0]    best_idx_q, best_idx_d;
    logic [daddr_width_p-1:0]   rr_addr_q, rr_addr_d;
    logic                       hit_q, hit_d;
    logic [lg_offsets_p:0]      offset_q, offset_d;
    logic                       offset_v_q, offset_v_d;
    logic                       phase_done_q, phase_done_d;
    logic [score_width_p-1:0]   score_q [num_offsets_lp];
    logic [score_width_p-1:0]   score_d [num_offsets_lp];

    logic [lg_offsets_p:0]      cand_plus1_s;
    logic [daddr_width_p-1:0]   cand_bytes_s;
    logic [score_width_p-1:0]   cur_score_s, new_score_s, new_best_score_s;
    logic [lg_offsets_p-1:0]    new_best_idx_s;
    logic [round_width_lp-1:0]  round_inc_s;
    logic                       cand_last_s, phase_end_s;

    // Scoring arithmetic shared by the probe address and the update step
    always_comb begin
        cand_plus1_s = {1'b0, cand_idx_q} + (lg_offsets_p + 1)'(1);
        cand_bytes_s = {{(daddr_width_p - lg_offsets_p - 1){1'b0}}, cand_plus1_s} << block_offset_width_p;
        cur_score_s  = score_q[cand_idx_q];
        if (hit_q && (cur_score_s != score_max_lp)) begin
            new_score_s = cur_score_s + score_width_p'(1);
        end else begin
            new_score_s = cur_score_s;
        end
        // Strict compare keeps the earlier (lower) index on a tie
        if (new_score_s > best_score_q) begin
            new_best_score_s = new_score_s;
            new_best_idx_s   = cand_idx_q;
        end else begin
            new_best_score_s = best_score_q;
            new_best_idx_s   = best_idx_q;
        end
        cand_last_s = &cand_idx_q;
        round_inc_s = round_cnt_q + round_width_lp'(1);
        phase_end_s = (new_score_s == score_max_lp) || (cand_last_s && (round_inc_s == round_max_lp));
    end

    // Next-state and datapath update for the phase sequencer
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        cand_idx_d   = cand_idx_q;
        round_cnt_d  = round_cnt_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        rr_addr_d    = rr_addr_q;
        hit_d        = hit_q;
        offset_d     = offset_q;
        offset_v_d   = offset_v_q;
        phase_done_d = 1'b0;
        score_d      = score_q;
        case (state_q)
            e_clear: begin
                score_d[clr_idx_q] = '0;
                best_score_d       = '0;
                best_idx_d         = '0;
                cand_idx_d         = '0;
                round_cnt_d        = '0;
                if (&clr_idx_q) begin
                    clr_idx_d = '0;
                    state_d   = e_idle;
                end else begin
                    clr_idx_d = clr_idx_q + lg_offsets_p'(1);
                end
            end
            e_idle: begin
                if (miss_v_i) begin
                    rr_addr_d = miss_addr_i - cand_bytes_s;
                    state_d   = e_probe;
                end else begin
                    state_d   = e_idle;
                end
            end
            e_probe: begin
                if (rr_ready_and_i) begin
                    state_d = e_wait;
                end else begin
                    state_d = e_probe;
                end
            end
            e_wait: begin
                if (rr_hit_v_i) begin
                    hit_d   = rr_hit_i;
                    state_d = e_update;
                end else begin
                    state_d = e_wait;
                end
            end
            e_update: begin
                score_d[cand_idx_q] = new_score_s;
                best_score_d        = new_best_score_s;
                best_idx_d          = new_best_idx_s;
                if (cand_last_s) begin
                    cand_idx_d  = '0;
                    round_cnt_d = round_inc_s;
                end else begin
                    cand_idx_d  = cand_idx_q + lg_offsets_p'(1);
                end
                // Result is loaded here so it appears alongside the phase_done pulse
                if (phase_end_s) begin
                    offset_d     = {1'b0, new_best_idx_s} + (lg_offsets_p + 1)'(1);
                    offset_v_d   = (new_best_score_s > bad_score_lp);
                    phase_done_d = 1'b1;
                    state_d      = e_publish;
                end else begin
                    state_d      = e_idle;
                end
            end
            e_publish: begin
                clr_idx_d = '0;
                state_d   = e_clear;
            end
            default: begin
                clr_idx_d = '0;
                state_d   = e_clear;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= e_clear;
            clr_idx_q    <= '0;
            cand_idx_q   <= '0;
            round_cnt_q  <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            rr_addr_q    <= '0;
            hit_q        <= 1'b0;
            offset_q     <= '0;
            offset_v_q   <= 1'b0;
            phase_done_q <= 1'b0;
            for (int i = 0; i < num_offsets_lp; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            cand_idx_q   <= cand_idx_d;
            round_cnt_q  <= round_cnt_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            rr_addr_q    <= rr_addr_d;
            hit_q        <= hit_d;
            offset_q     <= offset_d;
            offset_v_q   <= offset_v_d;
            phase_done_q <= phase_done_d;
            score_q      <= score_d;
        end
    end

    assign miss_yumi_o  = (state_q == e_idle) && miss_v_i;
    assign rr_v_o       = (state_q == e_probe);
    assign rr_addr_o    = rr_addr_q;
    assign offset_o     = offset_q;
    assign offset_v_o   = offset_v_q;
    assign phase_done_o = phase_done_q;

`ifdef BP_ME_BO_SCHED_STATS_EN
    logic [31:0] phase_cnt_q, phase_cnt_d;
    logic [31:0] disabled_cnt_q, disabled_cnt_d;

    // offset_v_q already holds this publish's verdict during e_publish
    always_comb begin
        phase_cnt_d    = phase_cnt_q;
        disabled_cnt_d = disabled_cnt_q;
        if (state_q == e_publish) begin
            phase_cnt_d = phase_cnt_q + 32'd1;
            if (!offset_v_q) begin
                disabled_cnt_d = disabled_cnt_q + 32'd1;
            end else begin
                disabled_cnt_d = disabled_cnt_q;
            end
        end else begin
            phase_cnt_d = phase_cnt_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_cnt_q    <= 32'd0;
            disabled_cnt_q <= 32'd0;
        end else begin
            phase_cnt_q    <= phase_cnt_d;
            disabled_cnt_q <= disabled_cnt_d;
        end
    end

    assign phase_cnt_o    = phase_cnt_q;
    assign disabled_cnt_o = disabled_cnt_q;
`endif

endmodule

// File: tb/tb_bp_me_best_offset_scheduler.sv
// Directed + randomized bench for bp_me_best_offset_scheduler, checked against a score-table model.
module tb_bp_me_best_offset_scheduler;

    localparam int aw    = 64;
    localparam int lg    = 2;
    localparam int bow   = 6;
    localparam int n_off = 4;
    localparam int smax  = 3;
    localparam int rmax  = 4;
    localparam int bad   = 1;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [aw-1:0] miss_addr_i;
    logic          miss_v_i;
    logic          miss_yumi_o;
    logic [aw-1:0] rr_addr_o;
    logic          rr_v_o;
    logic          rr_ready_and_i;
    logic          rr_hit_v_i;
    logic          rr_hit_i;
    logic [lg:0]   offset_o;
    logic          offset_v_o;
    logic          phase_done_o;
`ifdef BP_ME_BO_SCHED_STATS_EN
    logic [31:0]   phase_cnt_o;
    logic [31:0]   disabled_cnt_o;
`endif

    always #5 clk = ~clk;

    bp_me_best_offset_scheduler #(
        .daddr_width_p(aw), .lg_offsets_p(lg), .block_offset_width_p(bow),
        .score_width_p(5), .score_max_p(smax), .round_max_p(rmax), .bad_score_p(bad)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .miss_addr_i(miss_addr_i), .miss_v_i(miss_v_i), .miss_yumi_o(miss_yumi_o),
        .rr_addr_o(rr_addr_o), .rr_v_o(rr_v_o), .rr_ready_and_i(rr_ready_and_i),
        .rr_hit_v_i(rr_hit_v_i), .rr_hit_i(rr_hit_i),
        .offset_o(offset_o), .offset_v_o(offset_v_o), .phase_done_o(phase_done_o)
`ifdef BP_ME_BO_SCHED_STATS_EN
        , .phase_cnt_o(phase_cnt_o), .disabled_cnt_o(disabled_cnt_o)
`endif
    );

    int tests = 0;
    int fails = 0;
    int pops_seen = 0;

    // Reference model: score table and phase bookkeeping
    int m_score [n_off];
    int m_best_score, m_best_idx, m_cand, m_round, m_offset, m_pops, exp_wait;
    bit m_offset_v;
    logic [aw-1:0] last_rr_addr;
    logic          last_phase_done;

    always @(posedge clk) begin
        if (reset_i === 1'b0 && miss_v_i === 1'b1 && miss_yumi_o === 1'b1) pops_seen++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_phase_reset();
        for (int i = 0; i < n_off; i++) m_score[i] = 0;
        m_best_score = 0;
        m_best_idx   = 0;
        m_cand       = 0;
        m_round      = 0;
    endtask

    task automatic model_update(input bit hit, output bit ended);
        int s;
        if (hit && m_score[m_cand] < smax) m_score[m_cand] = m_score[m_cand] + 1;
        s = m_score[m_cand];
        if (s > m_best_score) begin
            m_best_score = s;
            m_best_idx   = m_cand;
        end
        ended = (s == smax);
        m_cand = m_cand + 1;
        if (m_cand == n_off) begin
            m_cand  = 0;
            m_round = m_round + 1;
            if (m_round == rmax) ended = 1'b1;
        end
        if (ended) begin
            m_offset   = m_best_idx + 1;
            m_offset_v = (m_best_score > bad);
            model_phase_reset();
        end
    endtask

    task automatic wait_pop(output int n);
        n = 0;
        #1;
        while (miss_yumi_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL pop_timeout observed=no pop expected=pop within 40 cycles");
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "pop handshake never arrived");
        end
    endtask

    task automatic do_miss(input logic [aw-1:0] addr, input bit hit, input int rdly,
                           input int pdly, input bit stray);
        int n;
        int ew;
        bit ended;
        logic [aw-1:0] exp_addr;
        ew = exp_wait;
        if (stray) begin
            rr_hit_v_i = 1'b1;
            rr_hit_i   = 1'b1;
            @(negedge clk);
            rr_hit_v_i = 1'b0;
            rr_hit_i   = 1'b0;
            if (ew > 0) ew--;
        end
        miss_addr_i = addr;
        miss_v_i    = 1'b1;
        wait_pop(n);
        check("pop_latency", n, ew);
        check("rr_v_idle", rr_v_o, 1'b0);
        exp_addr = addr - 64'((m_cand + 1) * 64);
        @(negedge clk);
        m_pops++;
        miss_addr_i = {$urandom, $urandom};
        check("rr_v_probe", rr_v_o, 1'b1);
        check("rr_addr", rr_addr_o, exp_addr);
        last_rr_addr = rr_addr_o;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check("rr_v_hold", rr_v_o, 1'b1);
            check("rr_addr_hold", rr_addr_o, exp_addr);
        end
        rr_ready_and_i = 1'b1;
        @(negedge clk);
        rr_ready_and_i = 1'b0;
        check("rr_v_wait", rr_v_o, 1'b0);
        for (int i = 0; i < pdly; i++) @(negedge clk);
        rr_hit_v_i = 1'b1;
        rr_hit_i   = hit;
        @(negedge clk);
        rr_hit_v_i = 1'b0;
        rr_hit_i   = 1'b0;
        miss_v_i   = 1'b0;
        model_update(hit, ended);
        @(negedge clk);
        last_phase_done = phase_done_o;
        check("phase_done", phase_done_o, ended);
        check("offset", offset_o, m_offset);
        check("offset_v", offset_v_o, m_offset_v);
        check("pop_count", pops_seen, m_pops);
        exp_wait = ended ? 5 : 0;
    endtask

    initial begin
        int n;
        reset_i        = 1'b1;
        miss_v_i       = 1'b1;
        miss_addr_i    = 64'h0;
        rr_ready_and_i = 1'b0;
        rr_hit_v_i     = 1'b0;
        rr_hit_i       = 1'b0;
        model_phase_reset();
        m_offset = 0; m_offset_v = 1'b0; m_pops = 0; exp_wait = 0;

        // Reset held 3 cycles with a pending miss
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_yumi", miss_yumi_o, 1'b0);
        end
        check("rst_rr_v", rr_v_o, 1'b0);
        check("rst_rr_addr", rr_addr_o, 64'h0);
        check("rst_offset", offset_o, 3'd0);
        check("rst_offset_v", offset_v_o, 1'b0);
        check("rst_phase_done", phase_done_o, 1'b0);
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("clear_yumi", miss_yumi_o, 1'b0);
            check("clear_offset_v", offset_v_o, 1'b0);
            @(negedge clk);
        end
        #1;
        check("first_pop_cycle5", miss_yumi_o, 1'b1);
        miss_v_i = 1'b0;

        // Address arithmetic and early saturation: only idx 2 hits
        for (int k = 0; k < 11; k++) begin
            logic [aw-1:0] a;
            a = {$urandom, $urandom};
            if (k == 1) a = 64'h40;
            if (k == 2) a = 64'h1000;
            do_miss(a, (k % 4) == 2, k % 2, (k + 1) % 3, 1'b0);
            if (k == 1) check("addr_wrap", last_rr_addr, 64'hFFFF_FFFF_FFFF_FFC0);
            if (k == 2) check("addr_0f40", last_rr_addr, 64'h0F40);
            if (k == 9) check("sat_not_early", last_phase_done, 1'b0);
        end
        check("sat_done", last_phase_done, 1'b1);
        check("sat_offset", offset_o, 3'd3);
        check("sat_offset_v", offset_v_o, 1'b1);

        // Round limit with no hits
        for (int k = 0; k < 16; k++) do_miss({$urandom, $urandom}, 1'b0, 0, 0, 1'b0);
        check("nowin_done", last_phase_done, 1'b1);
        check("nowin_offset", offset_o, 3'd1);
        check("nowin_offset_v", offset_v_o, 1'b0);

        // Tie between idx 1 and idx 3: lower index wins
        for (int k = 0; k < 16; k++)
            do_miss({$urandom, $urandom}, ((k % 4) == 1 || (k % 4) == 3) && (k / 4) < 2, 0, 0, 1'b0);
        check("tie_done", last_phase_done, 1'b1);
        check("tie_offset", offset_o, 3'd2);
        check("tie_offset_v", offset_v_o, 1'b1);

        // Backpressure, delayed response and a stray response in idle
        do_miss({$urandom, $urandom}, 1'b0, 0, 0, 1'b0);
        do_miss({$urandom, $urandom}, 1'b1, 5, 3, 1'b1);
        do_miss({$urandom, $urandom}, 1'b0, 2, 1, 1'b1);

        // Reset while a lookup is outstanding, with a late response afterwards
        miss_addr_i = {$urandom, $urandom};
        miss_v_i    = 1'b1;
        wait_pop(n);
        @(negedge clk);
        m_pops++;
        miss_v_i       = 1'b0;
        rr_ready_and_i = 1'b1;
        @(negedge clk);
        rr_ready_and_i = 1'b0;
        reset_i        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_i    = 1'b0;
        rr_hit_v_i = 1'b1;
        rr_hit_i   = 1'b1;
        check("midrst_offset", offset_o, 3'd0);
        check("midrst_offset_v", offset_v_o, 1'b0);
        check("midrst_rr_v", rr_v_o, 1'b0);
        @(negedge clk);
        rr_hit_v_i = 1'b0;
        rr_hit_i   = 1'b0;
        model_phase_reset();
        m_offset = 0; m_offset_v = 1'b0; exp_wait = 3;

        // Randomized traffic against the model
        for (int k = 0; k < 160; k++) begin
            do_miss({$urandom, $urandom}, $urandom_range(0, 2) == 0, $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
